// File: rtl/io_port_bank_if.sv
// CPU-side I/O bus seen by the port bank: strobes, address and write data in, read data out.
// Master drives the cycle; slave (the port bank) returns registered read data.
interface io_port_bank_if;
  logic        ioreq;
  logic        rd;
  logic        wr;
  logic [15:0] a;
  logic [7:0]  d;
  logic [7:0]  d_out;
  logic        d_out_active;

  modport master (output ioreq, rd, wr, a, d, input d_out, d_out_active);
  modport slave  (input ioreq, rd, wr, a, d, output d_out, d_out_active);
endinterface

// File: rtl/io_port_bank.sv
// Z80 I/O port bank: NCH address/mask decoded write registers with lock, sync and registered read.
// Latency: writes and reads take effect one clk28 edge after qualification; no backpressure, one write per bus cycle.
// IO_PORT_BANK_READBACK_EN: when defined, channels without ext_rd_en read back their own register.
module io_port_bank #(
  parameter int                  NCH       = 4,
  parameter logic [NCH*16-1:0]   MATCH     = {16'h1FFD, 16'hDFFD, 16'h7FFD, 16'h00FE},
  parameter logic [NCH*16-1:0]   MASK      = {16'hFFFF, 16'hFFFF, 16'h8002, 16'h0001},
  parameter logic [NCH*8-1:0]    RESET_VAL = '0,
  parameter logic [NCH-1:0]      LOCK_MASK = 4'b0010,
  parameter int                  LOCK_BIT  = 5,
  parameter logic [NCH-1:0]      SYNC_MASK = 4'b0001
) (
  input  logic               clk28,
  input  logic               rst_n,
  io_port_bank_if.slave      bus,
  input  logic [NCH-1:0]     en,
  input  logic               clkcpu_ck,
  input  logic [NCH-1:0]     ext_rd_en,
  input  logic [NCH*8-1:0]   ext_rd_data,
  input  logic [NCH-1:0]     unlock,
  output logic [NCH*8-1:0]   q,
  output logic [NCH-1:0]     wr_stb,
  output logic [NCH-1:0]     locked,
  output logic               collision
);

  logic [NCH-1:0] hit;
  logic [NCH-1:0] wq;
  logic [NCH-1:0] rd_hit;
  logic [NCH-1:0] done;
  logic [3:0]     nhit;
  logic [7:0]     rd_dat;
  logic           wr_cyc;
  // Cleared by reset, set once the bus has been seen idle: a write still held
  // across reset release must not be accepted.
  logic           wr_armed;

  assign wr_cyc = bus.ioreq && bus.wr;

  always_comb begin
    hit    = '0;
    wq     = '0;
    rd_hit = '0;
    nhit   = '0;
    rd_dat = '0;
    for (int i = 0; i < NCH; i++) begin
      hit[i] = en[i] && bus.ioreq &&
               (((bus.a ^ MATCH[16*i +: 16]) & MASK[16*i +: 16]) == 16'h0000);
      wq[i]  = hit[i] && bus.wr && !done[i] && wr_armed &&
               (!locked[i] || unlock[i]) && (!SYNC_MASK[i] || clkcpu_ck);
`ifdef IO_PORT_BANK_READBACK_EN
      rd_hit[i] = hit[i] && bus.rd;
`else
      rd_hit[i] = hit[i] && bus.rd && ext_rd_en[i];
`endif
      nhit = nhit + 4'(hit[i]);
    end
    // Descending scan so the lowest-index read hit wins.
    for (int i = NCH - 1; i >= 0; i--) begin
      if (rd_hit[i]) begin
`ifdef IO_PORT_BANK_READBACK_EN
        rd_dat = ext_rd_en[i] ? ext_rd_data[8*i +: 8] : q[8*i +: 8];
`else
        rd_dat = ext_rd_data[8*i +: 8];
`endif
      end
    end
  end

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      q                <= RESET_VAL;
      wr_stb           <= '0;
      locked           <= '0;
      done             <= '0;
      wr_armed         <= 1'b0;
      bus.d_out        <= 8'h00;
      bus.d_out_active <= 1'b0;
      collision        <= 1'b0;
    end else begin
      wr_stb <= wq;
      if (!wr_cyc) wr_armed <= 1'b1;
      for (int i = 0; i < NCH; i++) begin
        if (wq[i]) begin
          q[8*i +: 8] <= bus.d;
          done[i]     <= 1'b1;
        end else if (!wr_cyc) begin
          done[i] <= 1'b0;
        end
        // An accepted write outranks a simultaneous unlock.
        if (!LOCK_MASK[i])   locked[i] <= 1'b0;
        else if (wq[i])      locked[i] <= bus.d[LOCK_BIT];
        else if (unlock[i])  locked[i] <= 1'b0;
      end
      bus.d_out_active <= |rd_hit;
      if (|rd_hit) bus.d_out <= rd_dat;
      if (bus.ioreq && (bus.rd || bus.wr) && (nhit >= 4'd2)) collision <= 1'b1;
    end
  end

endmodule

// File: tb/tb_io_port_bank.sv
// Bench for io_port_bank: directed scenarios with literal expectations, then random bus traffic
// compared every cycle against a behavioural model of the port bank.
module tb_io_port_bank;
  localparam int         NCH       = 4;
  localparam logic [63:0] MATCH    = {16'h1FFD, 16'hDFFD, 16'h7FFD, 16'h00FE};
  // Channel 2 ignores a[15:14] so it also decodes 0x1FFD alongside channel 3.
  localparam logic [63:0] MASK     = {16'hFFFF, 16'h3FFF, 16'h8002, 16'h0001};
  localparam logic [31:0] RESET_VAL = 32'h0;
  localparam logic [3:0]  LOCK_MASK = 4'b0010;
  localparam logic [3:0]  SYNC_MASK = 4'b0001;
  localparam int          LOCK_BIT  = 5;
`ifdef IO_PORT_BANK_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic clk28 = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk28 = ~clk28;

  io_port_bank_if bus ();
  logic [3:0]  en, ext_rd_en, unlock, wr_stb, locked;
  logic        clkcpu_ck, collision;
  logic [31:0] ext_rd_data, q;

  io_port_bank #(
    .NCH(NCH), .MATCH(MATCH), .MASK(MASK), .RESET_VAL(RESET_VAL),
    .LOCK_MASK(LOCK_MASK), .LOCK_BIT(LOCK_BIT), .SYNC_MASK(SYNC_MASK)
  ) dut (
    .clk28(clk28), .rst_n(rst_n), .bus(bus), .en(en), .clkcpu_ck(clkcpu_ck),
    .ext_rd_en(ext_rd_en), .ext_rd_data(ext_rd_data), .unlock(unlock),
    .q(q), .wr_stb(wr_stb), .locked(locked), .collision(collision)
  );

  int n_pass = 0;
  int n_tot  = 0;
  bit chk_on = 1'b0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // Behavioural model: per-channel register, one-write-per-bus-cycle bookkeeping,
  // lock bit, lowest-index read select and sticky collision.
  logic [7:0] m_q [4];
  logic [3:0] m_stb, m_lock, m_used;
  logic       m_idle_seen, m_dact, m_coll;
  logic [7:0] m_dout;
  bit   [3:0] h;
  int         rs, nh;
  bit         acc;

  always @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) m_q[i] = RESET_VAL[8*i +: 8];
      m_stb = 0; m_lock = 0; m_used = 0; m_idle_seen = 0;
      m_dact = 0; m_dout = 0; m_coll = 0;
    end else begin
      for (int i = 0; i < 4; i++)
        h[i] = en[i] && bus.ioreq && ((bus.a & MASK[16*i +: 16]) == (MATCH[16*i +: 16] & MASK[16*i +: 16]));
      nh = $countones(h);
      rs = -1;
      for (int i = 3; i >= 0; i--)
        if (h[i] && bus.rd && (RB || ext_rd_en[i])) rs = i;
      m_dact = (rs >= 0);
      if (rs >= 0) m_dout = ext_rd_en[rs] ? ext_rd_data[8*rs +: 8] : m_q[rs];
      for (int i = 0; i < 4; i++) begin
        acc = h[i] && bus.wr && !m_used[i] && m_idle_seen && (!m_lock[i] || unlock[i]) &&
              (!SYNC_MASK[i] || clkcpu_ck);
        m_stb[i] = acc;
        if (acc) m_q[i] = bus.d;
        if (acc) m_used[i] = 1;
        else if (!(bus.ioreq && bus.wr)) m_used[i] = 0;
        if (LOCK_MASK[i]) begin
          if (acc) m_lock[i] = bus.d[LOCK_BIT];
          else if (unlock[i]) m_lock[i] = 0;
        end
      end
      if (bus.ioreq && (bus.rd || bus.wr) && nh >= 2) m_coll = 1;
      if (!(bus.ioreq && bus.wr)) m_idle_seen = 1;
    end
  end

  always @(negedge clk28) begin
    if (chk_on) begin
      check("q", 64'(q), 64'({m_q[3], m_q[2], m_q[1], m_q[0]}));
      check("wr_stb", 64'(wr_stb), 64'(m_stb));
      check("locked", 64'(locked), 64'(m_lock));
      check("d_out_active", 64'(bus.d_out_active), 64'(m_dact));
      check("d_out", 64'(bus.d_out), 64'(m_dout));
      check("collision", 64'(collision), 64'(m_coll));
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk28); #2; end
  endtask

  task automatic idle();
    bus.ioreq = 0; bus.rd = 0; bus.wr = 0;
  endtask

  function automatic logic [15:0] pick_addr();
    logic [15:0] tbl [6];
    tbl[0] = 16'h00FE; tbl[1] = 16'h7FFD; tbl[2] = 16'hDFFD;
    tbl[3] = 16'h1FFD; tbl[4] = 16'h5FFD; tbl[5] = 16'($urandom);
    return tbl[$urandom_range(0, 5)];
  endfunction

  int pulses;

  initial begin
    idle();
    bus.a = 0; bus.d = 0; en = 4'hF; ext_rd_en = 0; ext_rd_data = 0;
    unlock = 0; clkcpu_ck = 0;
    #1 rst_n = 0;
    chk_on = 1;
    cyc(2);
    check("rst_q", 64'(q), 64'h0);
    check("rst_wr_stb", 64'(wr_stb), 64'h0);
    check("rst_locked", 64'(locked), 64'h0);
    check("rst_d_out_active", 64'(bus.d_out_active), 64'h0);
    check("rst_d_out", 64'(bus.d_out), 64'h0);
    check("rst_collision", 64'(collision), 64'h0);
    rst_n = 1;
    cyc(1);

    // Synchronised channel waits for clkcpu_ck.
    bus.a = 16'h00FE; bus.d = 8'h15; bus.ioreq = 1; bus.wr = 1;
    cyc(5);
    check("sync_hold_q0", 64'(q[7:0]), 64'h00);
    check("sync_hold_stb", 64'(wr_stb), 64'h0);
    clkcpu_ck = 1;
    cyc(1);
    check("sync_q0", 64'(q[7:0]), 64'h15);
    check("sync_stb", 64'(wr_stb), 64'h1);
    clkcpu_ck = 0;
    cyc(1);
    check("sync_stb_drop", 64'(wr_stb), 64'h0);
    idle(); cyc(1);

    // Long write: one strobe, lock set, following write ignored.
    bus.a = 16'h7FFD; bus.d = 8'h27; bus.ioreq = 1; bus.wr = 1;
    pulses = 0;
    repeat (20) begin cyc(1); if (wr_stb[1]) pulses++; end
    check("long_wr_pulses", 64'(pulses), 64'd1);
    check("long_wr_q1", 64'(q[15:8]), 64'h27);
    check("long_wr_locked", 64'(locked[1]), 64'h1);
    idle(); cyc(1);
    bus.d = 8'h03; bus.ioreq = 1; bus.wr = 1;
    pulses = 0;
    repeat (3) begin cyc(1); if (wr_stb[1]) pulses++; end
    check("locked_wr_q1", 64'(q[15:8]), 64'h27);
    check("locked_wr_pulses", 64'(pulses), 64'd0);
    idle(); cyc(1);

    // Unlock together with a write: the write wins.
    unlock = 4'b0010; bus.d = 8'h01; bus.ioreq = 1; bus.wr = 1;
    cyc(1);
    check("unlock_q1", 64'(q[15:8]), 64'h01);
    check("unlock_locked", 64'(locked[1]), 64'h0);
    unlock = 0; idle(); cyc(1);

    // Read path, register then external data.
    bus.a = 16'hDFFD; bus.d = 8'hA5; bus.ioreq = 1; bus.wr = 1;
    cyc(1); idle(); cyc(1);
    bus.ioreq = 1; bus.rd = 1;
    cyc(1);
`ifdef IO_PORT_BANK_READBACK_EN
    check("rd_reg_active", 64'(bus.d_out_active), 64'h1);
    check("rd_reg_data", 64'(bus.d_out), 64'hA5);
`else
    check("rd_reg_active", 64'(bus.d_out_active), 64'h0);
`endif
    ext_rd_en = 4'b0100; ext_rd_data = 32'h003C_0000;
    cyc(1);
    check("rd_ext_active", 64'(bus.d_out_active), 64'h1);
    check("rd_ext_data", 64'(bus.d_out), 64'h3C);
    idle(); cyc(1);
    check("rd_drop_active", 64'(bus.d_out_active), 64'h0);
    check("rd_hold_data", 64'(bus.d_out), 64'h3C);

    // Two channels decode 0x1FFD: lowest wins, collision sticks.
    check("pre_collision", 64'(collision), 64'h0);
    en = 4'b1101; ext_rd_en = 4'b1100; ext_rd_data = 32'h993C_0000;
    bus.a = 16'h1FFD; bus.ioreq = 1; bus.rd = 1;
    cyc(1);
    check("multi_rd_data", 64'(bus.d_out), 64'h3C);
    check("multi_collision", 64'(collision), 64'h1);
    idle(); en = 4'hF; ext_rd_en = 0;
    cyc(5);
    check("collision_sticky", 64'(collision), 64'h1);

    // Reset in the middle of a held write.
    bus.a = 16'h00FE; bus.d = 8'h5A; clkcpu_ck = 1; bus.ioreq = 1; bus.wr = 1;
    cyc(1);
    check("pre_rst_q0", 64'(q[7:0]), 64'h5A);
    #1 rst_n = 0;
    #1;
    check("mid_rst_q", 64'(q), 64'(RESET_VAL));
    check("mid_rst_collision", 64'(collision), 64'h0);
    cyc(1);
    rst_n = 1;
    pulses = 0;
    repeat (4) begin cyc(1); if (wr_stb != 0) pulses++; end
    check("post_rst_pulses", 64'(pulses), 64'd0);
    check("post_rst_q", 64'(q), 64'(RESET_VAL));
    bus.wr = 0; cyc(1);
    bus.wr = 1; cyc(1);
    check("rewrite_stb", 64'(wr_stb), 64'h1);
    check("rewrite_q0", 64'(q[7:0]), 64'h5A);
    idle(); clkcpu_ck = 0; cyc(1);

    // Random traffic against the model.
    repeat (3000) begin
      bus.ioreq   = ($urandom_range(0, 9) < 7);
      bus.rd      = $urandom_range(0, 1);
      bus.wr      = $urandom_range(0, 1);
      bus.a       = pick_addr();
      bus.d       = 8'($urandom);
      en          = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      unlock      = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
      clkcpu_ck   = $urandom_range(0, 1);
      ext_rd_en   = 4'($urandom);
      ext_rd_data = $urandom;
      if ($urandom_range(0, 199) == 0) begin
        rst_n = 0; cyc(1); rst_n = 1;
      end
      cyc($urandom_range(1, 4));
    end
    idle(); cyc(2);
    chk_on = 0;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/io_port_bank.md
Name: io_port_bank

Overview:
- Parametrised Z80 I/O port register bank. Generalises the fixed-port decoder to NCH address/mask-decoded channels.
- Each channel provides:
  - a write register with optional write-lock;
  - optional CPU-clock-synchronised write;
  - a one-shot write strobe;
  - a registered read path with priority arbitration.
- Sits between the CPU bus signals and the memory/video/sound control logic in the CPLD top level.

Parameters:
- NCH, 4: number of port channels (1..8).
- MATCH, {16'h1FFD,16'hDFFD,16'h7FFD,16'h00FE}: NCH×16 packed. Channel i address value is MATCH[16i+15:16i].
- MASK, {16'hFFFF,16'hFFFF,16'h8002,16'h0001}: NCH×16 packed. A 1 bit means that address bit is compared.
- RESET_VAL, 0: NCH×8 packed register reset values.
- LOCK_MASK, 4'b0010: channels whose data bit LOCK_BIT acts as a write lock.
- LOCK_BIT, 5: data bit index used as the lock bit (0..7).
- SYNC_MASK, 4'b0001: channels whose writes are qualified by clkcpu_ck.

Ports:
- clk28  in  1  system clock, 28 MHz
- rst_n  in  1  asynchronous active-low reset
- en  in  NCH  per-channel enable. When 0, the channel never matches.
- clkcpu_ck  in  1  CPU clock phase strobe, used by SYNC_MASK channels
- ioreq  in  1  I/O cycle active
- rd  in  1  read strobe
- wr  in  1  write strobe
- a  in  16  CPU address
- d  in  8  CPU write data
- ext_rd_en  in  NCH  per channel: read data comes from ext_rd_data instead of the register
- ext_rd_data  in  NCH×8  external read data
- unlock  in  NCH  per channel: clear the lock flag (e.g. profi override)
- q  out  NCH×8  channel register contents
- wr_stb  out  NCH  one-cycle pulse on each accepted write
- locked  out  NCH  lock flag per channel
- d_out  out  8  read data to the bus controller
- d_out_active  out  1  d_out valid
- collision  out  1  sticky flag: more than one channel matched a cycle

Behaviour:
- Reset (asynchronous, rst_n=0) sets:
  - q = RESET_VAL;
  - wr_stb = 0, locked = 0, d_out_active = 0, d_out = 0, collision = 0;
  - all internal done flags = 0.
- Match: hit[i] = en[i] && ioreq && ((a ^ MATCH_i) & MASK_i) == 0.
- Write qualification: wq[i] = hit[i] && wr && !done[i] && (!locked[i] || unlock[i]) && (!SYNC_MASK[i] || clkcpu_ck).
- Write acceptance:
  - At the clk28 edge after wq[i] is high: q_i <= d and wr_stb[i] <= 1 for exactly one cycle.
  - done[i] <= 1 on that same edge.
  - done[i] clears on the first cycle where !(ioreq && wr).
  - Result: exactly one accepted write per bus cycle, however long wr is held.
- Lock flag:
  - For LOCK_MASK[i] channels, locked[i] <= d[LOCK_BIT] on every accepted write.
  - unlock[i] high clears locked[i] on the next edge, unless a write accepted on the same edge sets it again; the write takes priority.
  - A write attempted while locked[i]=1 and unlock[i]=0 is ignored: no wr_stb, q unchanged.
  - Non-LOCK_MASK channels keep locked = 0.
- Read path:
  - rsel is the lowest index i with hit[i] && rd.
  - Next edge:
    - d_out_active <= |(hit & rd);
    - d_out <= ext_rd_en[rsel] ? ext_rd_data[rsel] : q_rsel;
    - d_out holds its value when there is no hit.
  - Latency is 1 clk28. d_out_active drops one cycle after rd/ioreq deassert.
- Collision: on any cycle with ioreq && (rd||wr) and two or more channels hit, collision <= 1. It stays set until reset.
- Simultaneous multi-hit writes: every qualifying channel accepts independently; there is no priority on writes.
- Changing en[i] mid-cycle takes effect on the next evaluation. done[i] still clears only via wr/ioreq deassert.
- Reset during an active write aborts it: no wr_stb is produced after reset release until a fresh write edge.

Optional Feature:
- Macro IO_PORT_BANK_READBACK_EN.
- Defined: register readback as described, using q when ext_rd_en[i]=0.
- Not defined:
  - channels with ext_rd_en[i]=0 do not participate in reads: excluded from rsel and from d_out_active;
  - the q read mux is not built;
  - writes, lock and collision behave identically.

Test Plan:
- Reset, then write 0x15 to a=0x00FE while clkcpu_ck is held 0 for 5 cycles, then pulsed → no update while clkcpu_ck=0; on the first pulse, q0=0x15 and wr_stb[0] high for 1 cycle.
- Hold wr 20 cycles to a=0x7FFD with d=0x27 → exactly one wr_stb[1] pulse, q1=0x27, locked[1]=1. A second write of 0x03 is ignored, q1 stays 0x27.
- With locked[1]=1, assert unlock[1] together with a write of 0x01 → q1=0x01, locked[1]=0 (write wins, d[5]=0).
- Read a=0xDFFD with ext_rd_en=0 after writing 0xA5 → d_out=0xA5, d_out_active=1 one cycle after rd. Repeat with ext_rd_en[2]=1, ext_rd_data=0x3C → d_out=0x3C.
- Set MATCH so ch2 and ch3 both decode 0x1FFD, then read → d_out from ch2 and collision=1 (sticky) until rst_n.
- Assert rst_n=0 mid-write with wr held high → q=RESET_VAL, no wr_stb after release until wr is deasserted and reasserted.
